// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: burst-locked round-robin arbiter, N valid/ready
// sources onto one valid/ready sink. Optional output skid: STREAM_ARB_SKID_EN.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   up_valid   per-requester valid            [N]
//   up_data    requester i beat at [i*DW +: DW]
//   up_ready   per-requester ready            [N]
//   down_valid / down_data / down_ready       downstream stream
//   grant_o    one-hot owner while locked, 0 when idle
//   id_o       index of current or last owner
//
// STREAM_ARB_SKID_EN defined: a registered 2-entry skid buffer drives
// down_*, breaking the down_ready -> up_ready combinational path.
module stream_rr_arbiter #(
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         up_valid,
    input  logic [N*DW-1:0]      up_data,
    output logic [N-1:0]         up_ready,
    output logic                 down_valid,
    output logic [DW-1:0]        down_data,
    input  logic                 down_ready,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] id_o
);

    localparam int IW = $clog2(N);
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          lock;
    logic          own_valid;
    logic [DW-1:0] own_data;
    logic          int_ready;
    logic          xfer;
    logic          release_now;
    logic [IW-1:0] pick;
    logic          found;
    logic [IW-1:0] owner_next;

    assign lock      = (state_q == S_LOCK);
    assign own_valid = up_valid[owner_q];
    assign own_data  = up_data[int'(owner_q)*DW +: DW];
    assign xfer      = lock & own_valid & int_ready;

    // Burst ends on its last beat, or early when the owner stops asking.
    assign release_now = lock &
                         ((xfer & (cnt_q == CNT_LAST)) | ~own_valid);

    assign owner_next = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && up_valid[(int'(ptr_q) + k) % N]) begin
                found = 1'b1;
                pick  = IW'((int'(ptr_q) + k) % N);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (|up_valid) begin
                    owner_d = pick;
                    cnt_d   = '0;
                    state_d = S_LOCK;
                end
            end
            S_LOCK: begin
                if (release_now) begin
                    ptr_d   = owner_next;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        up_ready = '0;
        grant_o  = '0;
        if (lock) begin
            up_ready[owner_q] = int_ready;
            grant_o[owner_q]  = 1'b1;
        end
    end

    assign id_o = owner_q;

`ifdef STREAM_ARB_SKID_EN

    logic [1:0][DW-1:0] mem_q, mem_d;
    logic               wr_q, wr_d;
    logic               rd_q, rd_d;
    logic [1:0]         fill_q, fill_d;
    logic               pop;

    assign int_ready  = (fill_q != 2'd2);
    assign pop        = (fill_q != 2'd0) & down_ready;
    assign down_valid = (fill_q != 2'd0);
    assign down_data  = mem_q[rd_q];

    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        fill_d = fill_q;
        if (xfer) begin
            mem_d[wr_q] = own_data;
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        if (xfer && !pop) begin
            fill_d = fill_q + 2'd1;
        end else if (!xfer && pop) begin
            fill_d = fill_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q  <= '0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            fill_q <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            fill_q <= fill_d;
        end
    end

`else

    assign int_ready  = down_ready;
    assign down_valid = lock & own_valid;
    assign down_data  = lock ? own_data : '0;

`endif

endmodule
